cms_axis_packer_96to64: RTL

//   Downstream stage of continuous_monitoring_system. Consumes its 96-bit AXI-Stream trace items
//   (one item per retired pc/instr) and repacks them into a dense 64-bit AXI-Stream for the DMA/FIFO.
//   Two items map to three output beats with no padding. A packet end (tlast) forces a flush of any

---
 rtl/cms_pkg.sv | 18 +
 rtl/cms_axis_packer_96to64.sv | 131 +++++++++++++
 2 files changed

// File: rtl/cms_pkg.sv
// Shared constants and types for the continuous_monitoring_system trace path.
package cms_pkg;

   localparam int unsigned CMS_ITEM_W = 96;
   localparam int unsigned CMS_BEAT_W = 64;
   localparam int unsigned CMS_KEEP_W = CMS_BEAT_W / 8;

   localparam logic [CMS_KEEP_W-1:0] KEEP_FULL = 8'hFF;
   localparam logic [CMS_KEEP_W-1:0] KEEP_HALF = 8'h0F;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      R32     = 2'd1,
      R64     = 2'd2,
      FLUSH32 = 2'd3
   } packer_state_t;

endpackage : cms_pkg

// File: rtl/cms_axis_packer_96to64.sv
// Repacks 96-bit trace items into a dense 64-bit AXI-Stream (2 items -> 3 beats);
// a packet end flushes any 32-bit residue so packets always close on a beat boundary.
module cms_axis_packer_96to64
   import cms_pkg::*;
#(
   parameter int unsigned IN_WIDTH      = CMS_ITEM_W,
   parameter int unsigned OUT_WIDTH     = CMS_BEAT_W,
   parameter int unsigned PKT_CNT_WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     S_AXIS_tvalid,
   output logic                     S_AXIS_tready,
   input  logic [IN_WIDTH-1:0]      S_AXIS_tdata,
   input  logic                     S_AXIS_tlast,
   output logic                     M_AXIS_tvalid,
   input  logic                     M_AXIS_tready,
   output logic [OUT_WIDTH-1:0]     M_AXIS_tdata,
   output logic [OUT_WIDTH/8-1:0]   M_AXIS_tkeep,
   output logic                     M_AXIS_tlast,
   output logic [PKT_CNT_WIDTH-1:0] pkt_cnt
);

   if (IN_WIDTH != CMS_ITEM_W || OUT_WIDTH != CMS_BEAT_W) begin : g_bad_width
      $error("cms_axis_packer_96to64 supports only IN_WIDTH=96 and OUT_WIDTH=64");
   end

   packer_state_t            state_q, state_d;
   logic [63:0]              res_q, res_d;
   logic                     pend_last_q, pend_last_d;
   logic                     m_valid_q, m_valid_d;
   logic [63:0]              m_data_q, m_data_d;
   logic [7:0]               m_keep_q, m_keep_d;
   logic                     m_last_q, m_last_d;
   logic [PKT_CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;

   logic out_free_c;
   logic s_ready_c;
   logic s_hs_c;
   logic m_hs_c;

   // Input is only taken in states that emit a beat from it; held off during reset.
   assign out_free_c = !m_valid_q || M_AXIS_tready;
   assign s_ready_c  = !rst && out_free_c && (state_q == EMPTY || state_q == R32);
   assign s_hs_c     = S_AXIS_tvalid && s_ready_c;
   assign m_hs_c     = m_valid_q && M_AXIS_tready;

   always_comb begin
      state_d     = state_q;
      res_d       = res_q;
      pend_last_d = pend_last_q;
      m_valid_d   = m_valid_q && !M_AXIS_tready;
      m_data_d    = m_data_q;
      m_keep_d    = m_keep_q;
      m_last_d    = m_last_q;
      pkt_cnt_d   = pkt_cnt_q + ((m_hs_c && m_last_q) ? PKT_CNT_WIDTH'(1) : PKT_CNT_WIDTH'(0));

      unique case (state_q)
         EMPTY: begin
            if (s_hs_c) begin
               m_valid_d = 1'b1;
               m_data_d  = S_AXIS_tdata[63:0];
               m_keep_d  = KEEP_FULL;
               m_last_d  = 1'b0;
               res_d     = {32'h0, S_AXIS_tdata[95:64]};
               state_d   = S_AXIS_tlast ? FLUSH32 : R32;
            end
         end
         R32: begin
            if (s_hs_c) begin
               m_valid_d   = 1'b1;
               m_data_d    = {S_AXIS_tdata[31:0], res_q[31:0]};
               m_keep_d    = KEEP_FULL;
               m_last_d    = 1'b0;
               res_d       = S_AXIS_tdata[95:32];
               pend_last_d = S_AXIS_tlast;
               state_d     = R64;
            end
         end
         R64: begin
            if (out_free_c) begin
               m_valid_d = 1'b1;
               m_data_d  = res_q;
               m_keep_d  = KEEP_FULL;
               m_last_d  = pend_last_q;
               state_d   = EMPTY;
            end
         end
         FLUSH32: begin
            if (out_free_c) begin
               m_valid_d = 1'b1;
               m_data_d  = {32'h0, res_q[31:0]};
               m_keep_d  = KEEP_HALF;
               m_last_d  = 1'b1;
               state_d   = EMPTY;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= EMPTY;
         res_q       <= '0;
         pend_last_q <= 1'b0;
         m_valid_q   <= 1'b0;
         m_data_q    <= '0;
         m_keep_q    <= '0;
         m_last_q    <= 1'b0;
         pkt_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         res_q       <= res_d;
         pend_last_q <= pend_last_d;
         m_valid_q   <= m_valid_d;
         m_data_q    <= m_data_d;
         m_keep_q    <= m_keep_d;
         m_last_q    <= m_last_d;
         pkt_cnt_q   <= pkt_cnt_d;
      end
   end

   assign S_AXIS_tready = s_ready_c;
   assign M_AXIS_tvalid = m_valid_q;
   assign M_AXIS_tdata  = m_data_q;
   assign M_AXIS_tkeep  = m_keep_q;
   assign M_AXIS_tlast  = m_last_q;
   assign pkt_cnt       = pkt_cnt_q;

endmodule : cms_axis_packer_96to64
